// File: rtl/eight_input_arbiter.sv
// Eight-requester arbiter: fixed or round-robin priority with a per-grant hold limit.
// Grant is registered (latency 1); each release inserts a one-cycle GAP, and timeout pulses on a forced release.
module eight_input_arbiter #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req,
  input  logic       rr_en,
  output logic [7:0] grant,
  output logic [3:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [3:0] id_q, id_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] win_q, win_d;

  logic       arb_found;
  logic [2:0] arb_idx;

  // Descending search; round-robin starts below the last winner so it ends up last.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      if (!arb_found && req[rr_en ? (ptr_q - 3'(k)) : 3'(8 - k)]) begin
        arb_found = 1'b1;
        arb_idx   = rr_en ? (ptr_q - 3'(k)) : 3'(8 - k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    case (state_q)
      IDLE, GAP: begin
        if (arb_found) begin
          state_d = GRANT;
          grant_d = 8'b1 << arb_idx;
          id_d    = 4'(arb_idx) + 4'd1;
          busy_d  = 1'b1;
          hold_d  = 8'd0;
          ptr_d   = arb_idx;
          win_d   = arb_idx;
        end else begin
          state_d = IDLE;
          grant_d = 8'h00;
          id_d    = 4'd0;
          busy_d  = 1'b0;
          hold_d  = 8'd0;
        end
      end
      GRANT: begin
        hold_d = hold_q + 8'd1;
        // A dropped request wins over the hold limit, so a coincident drop is a normal release.
        if (!req[win_q] || (hold_q == HOLD_LAST)) begin
          state_d   = GAP;
          grant_d   = 8'h00;
          id_d      = 4'd0;
          busy_d    = 1'b0;
          timeout_d = req[win_q];
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 8'h00;
        id_d    = 4'd0;
        busy_d  = 1'b0;
        hold_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= 8'h00;
      id_q      <= 4'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= 8'd0;
      ptr_q     <= 3'd0;
      win_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_eight_input_arbiter.sv
// Directed bench for eight_input_arbiter: default MAX_HOLD instance plus a MAX_HOLD=1 instance.
module tb_eight_input_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] req;
  logic       rr_en;
  logic [7:0] grant, grant1;
  logic [3:0] grant_id, grant_id1;
  logic       busy, busy1;
  logic       timeout, timeout1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eight_input_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req(req), .rr_en(rr_en),
    .grant(grant), .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  eight_input_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req), .rr_en(rr_en),
    .grant(grant1), .grant_id(grant_id1), .busy(busy1), .timeout(timeout1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 8'h00;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rr_seq [9];
    rr_seq = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd8};

    reset_n = 1'b0;
    req     = 8'h00;
    rr_en   = 1'b0;
    #3;
    chk("rst_grant", grant, 8'h00);
    chk("rst_id", grant_id, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_grant1", grant1, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_noreq", grant, 8'h00);

    // MAX_HOLD=1: one-cycle grant, GAP with timeout, regrant
    req = 8'h01;
    tick();
    chk("mh1_grant", grant1, 8'h01);
    chk("mh1_id", grant_id1, 4'd1);
    tick();
    chk("mh1_gap_grant", grant1, 8'h00);
    chk("mh1_gap_timeout", timeout1, 1'b1);
    tick();
    chk("mh1_regrant", grant1, 8'h01);
    chk("mh1_regrant_to", timeout1, 1'b0);
    do_reset();

    // Fixed priority, non-granted changes ignored, normal release
    rr_en = 1'b0;
    req = 8'b0010_0100;
    tick();
    chk("fix_grant", grant, 8'b0010_0000);
    chk("fix_id", grant_id, 4'b0110);
    chk("fix_busy", busy, 1'b1);
    req = 8'b1010_0100;
    tick();
    chk("fix_hold_ignore", grant, 8'b0010_0000);
    req = 8'b0000_0100;
    tick();
    chk("rel_gap_grant", grant, 8'h00);
    chk("rel_gap_busy", busy, 1'b0);
    chk("rel_gap_timeout", timeout, 1'b0);
    tick();
    chk("rel_next_grant", grant, 8'b0000_0100);
    chk("rel_next_id", grant_id, 4'b0011);
    req = 8'h00;
    tick();
    chk("rel_drop", grant, 8'h00);
    tick();
    chk("rel_idle", grant, 8'h00);
    do_reset();

    // Timeout after 15 cycles, then immediate regrant in fixed mode
    req = 8'h08;
    tick();
    chk("to_first", grant, 8'h08);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("to_hold", grant, 8'h08);
    end
    tick();
    chk("to_gap_grant", grant, 8'h00);
    chk("to_gap_id", grant_id, 4'd0);
    chk("to_gap_timeout", timeout, 1'b1);
    tick();
    chk("to_regrant", grant, 8'h08);
    chk("to_regrant_to", timeout, 1'b0);

    // Request drops on the edge the limit is reached: normal release
    for (int i = 0; i < 14; i++) tick();
    chk("sim_last_cycle", grant, 8'h08);
    req = 8'h00;
    tick();
    chk("sim_gap_grant", grant, 8'h00);
    chk("sim_gap_timeout", timeout, 1'b0);
    do_reset();

    // Round-robin rotation under continuous full request
    rr_en = 1'b1;
    req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      tick();
      chk("rr_id", grant_id, rr_seq[n]);
      chk("rr_grant", grant, 8'h01 << (rr_seq[n] - 4'd1));
      for (int i = 0; i < 14; i++) tick();
      tick();
      chk("rr_gap_grant", grant, 8'h00);
      chk("rr_gap_timeout", timeout, 1'b1);
    end
    rr_en = 1'b0;
    do_reset();

    // Asynchronous reset mid-grant
    req = 8'h80;
    tick();
    chk("ar_grant", grant, 8'h80);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_async_grant", grant, 8'h00);
    chk("ar_async_id", grant_id, 4'd0);
    chk("ar_async_busy", busy, 1'b0);
    req = 8'h01;
    tick();
    reset_n = 1'b1;
    tick();
    chk("ar_after_id", grant_id, 4'b0001);
    chk("ar_after_grant", grant, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eight_input_arbiter.md
EIGHT_INPUT_ARBITER -- requirements
Module: eight_input_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 15, giving the maximum consecutive grant cycles per requester (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 8, request lines, one per requester; index 7..0.
REQ-005 The block SHALL have port rr_en, input, 1, where 0 selects fixed priority and 1 selects round-robin priority.
REQ-006 The block SHALL have port grant, output, 8, a registered one-hot grant vector; all-zero when no grant.
REQ-007 The block SHALL have port grant_id, output, 4, the registered encoded winner: index+1 (4'b1000 for req[7] .. 4'b0001 for req[0]), 4'b0000 when no grant.
REQ-008 The block SHALL have port busy, output, 1, high exactly while grant is non-zero.
REQ-009 The block SHALL have port timeout, output, 1, a one-cycle pulse marking a forced release.

Function
REQ-010 The block SHALL implement three states: IDLE, GRANT, GAP; all outputs registered.
REQ-011 In IDLE, on an edge where req != 0, the block SHALL load the winner and enter GRANT, so grant is visible the cycle after req is first sampled high (latency 1).
REQ-012 With rr_en=0, the winner SHALL be the highest set index (req[7] highest, req[0] lowest).
REQ-013 With rr_en=1, the search SHALL start at last-granted index minus 1, descend, wrap 0->7, and give the last-granted index lowest priority.
REQ-014 The last-granted pointer SHALL update on every grant in both modes, reset to 0 (first round-robin order 7,6,..,0).
REQ-015 A change to rr_en SHALL take effect at the next arbitration only; it SHALL NOT disturb a grant in progress.
REQ-016 On entering GRANT, the 8-bit hold counter SHALL load 0; it SHALL increment on each GRANT cycle.
REQ-017 In GRANT, while req[winner]=1 and hold counter < MAX_HOLD-1, the grant SHALL be held unchanged.
REQ-018 If req[winner]=0 when sampled in GRANT, the block SHALL enter GAP with grant=0 and timeout=0 (normal release).
REQ-019 If req[winner]=1 and hold counter = MAX_HOLD-1, the block SHALL enter GAP with grant=0 and timeout=1 for that single GAP cycle (forced release).
REQ-020 If the request drops on the same edge the limit is reached, the release SHALL be treated as normal (timeout=0).
REQ-021 GAP SHALL last exactly one cycle with grant=0; on that edge it SHALL arbitrate as IDLE does, going to GRANT if req != 0 and to IDLE otherwise.
REQ-022 Changes on non-granted req lines during GRANT SHALL have no effect until the next arbitration.
REQ-023 A forcibly released requester still requesting SHALL compete normally; in fixed mode it MAY win again immediately after GAP.
REQ-024 With MAX_HOLD=1, each grant SHALL last exactly one cycle, followed by GAP with timeout=1 if the request is still high.
REQ-025 Exactly zero or one grant bit SHALL be high in every cycle, and grant_id SHALL always match grant.

Reset
REQ-026 While reset_n=0, the block SHALL asynchronously force state=IDLE, grant=8'h00, grant_id=4'b0000, busy=0, timeout=0, hold counter=0, pointer=0.
REQ-027 Reset asserted mid-GRANT SHALL drop the grant immediately, without waiting for a clock edge.
REQ-028 After reset_n rises, the first arbitration SHALL occur on the first rising edge that samples req != 0.

Verification
REQ-029 Fixed-priority scenario: rr_en=0, req=8'b0010_0100 -> next cycle grant=8'b0010_0000, grant_id=4'b0110, busy=1.
REQ-030 Release scenario: drop req[5] -> one GAP cycle with grant=0 -> next cycle grant=8'b0000_0100, grant_id=4'b0011.
REQ-031 Timeout scenario: MAX_HOLD=15, req[3] held high alone -> grant 15 cycles, then 1 GAP cycle with timeout=1, grant=0, then regrant to req[3].
REQ-032 Round-robin scenario: rr_en=1, req=8'hFF held until each timeout -> grant_id sequence 8,7,6,5,4,3,2,1,8, with a GAP between each.
REQ-033 Simultaneous-event scenario: req[winner] drops on the edge the hold counter reaches MAX_HOLD-1 -> GAP with timeout=0.
REQ-034 Reset-mid-grant scenario: reset_n=0 while grant=8'h80 -> grant=0 and grant_id=0 without a clock edge; after release with req=8'h01 -> grant_id=4'b0001.
